main_control_fsm: RTL

Multi-cycle sequencer for the processor.
- Walks each instruction through IF/ID/EX/MEM/WB and drives every datapath write strobe.
- Drives the 3-bit state bus that pc_control uses to pick pc_src.
- Stalls on a memory ready handshake and halts on HALT or an illegal opcode.
- Sits between the instruction register, pc_control, the ALU/register file and the unified memory port.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/main_control_fsm_if.sv | 21 ++
 rtl/ctrl_decode.sv | 112 +++++++++++
 rtl/main_control_fsm.sv | 89 ++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state codes, opcode map and strobe bundle for the sequencer
package cpu_pkg;

   localparam logic [2:0] ST_IF   = 3'b000;
   localparam logic [2:0] ST_ID   = 3'b001;
   localparam logic [2:0] ST_EX   = 3'b010;
   localparam logic [2:0] ST_MEM  = 3'b011;
   localparam logic [2:0] ST_WB   = 3'b100;
   localparam logic [2:0] ST_HALT = 3'b101;

   // Opcode map shared with pc_control so both blocks decode identically
   localparam logic [5:0] OP_ALU  = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b000001;
   localparam logic [5:0] OP_LW   = 6'b000100;
   localparam logic [5:0] OP_SW   = 6'b000101;
   localparam logic [5:0] OP_BR   = 6'b001010;
   localparam logic [5:0] OP_JMP  = 6'b001100;
   localparam logic [5:0] OP_CALL = 6'b001101;
   localparam logic [5:0] OP_RET  = 6'b001110;
   localparam logic [5:0] OP_HLT  = 6'b111111;

   typedef struct packed {
      logic mem_req;
      logic mem_we;
      logic mem_addr_sel;
      logic ir_write;
      logic pc_write;
      logic alu_src_imm;
      logic flags_write;
      logic reg_write;
      logic wb_sel;
      logic sp_inc;
      logic sp_dec;
   } ctrl_strobes_t;

endpackage

// File: rtl/main_control_fsm_if.sv
// rtl/main_control_fsm_if.sv - unified memory port handshake between sequencer and memory
interface main_control_fsm_if;
   logic mem_req;
   logic mem_we;
   logic mem_addr_sel;
   logic mem_ready;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr_sel,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr_sel,
      output mem_ready
   );
endinterface

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational (state, op, mem_ready) -> strobes and next state
module ctrl_decode
   import cpu_pkg::*;
(
   input  logic [2:0]    state_i,
   input  logic [5:0]    op_i,
   input  logic          mem_ready_i,
   output ctrl_strobes_t strobes_o,
   output logic [2:0]    next_state_o,
   output logic          retire_o,
   output logic          set_illegal_o
);

   always_comb begin
      strobes_o     = '0;
      next_state_o  = state_i;
      retire_o      = 1'b0;
      set_illegal_o = 1'b0;

      case (state_i)
         ST_IF: begin
            strobes_o.mem_req = 1'b1;
            if (mem_ready_i) begin
               strobes_o.ir_write = 1'b1;
               next_state_o       = ST_ID;
            end
         end

         ST_ID: begin
            case (op_i)
               OP_ALU, OP_ADDI, OP_LW, OP_SW: begin
                  strobes_o.pc_write = 1'b1;
                  next_state_o       = ST_EX;
               end
               OP_BR, OP_JMP: begin
                  strobes_o.pc_write = 1'b1;
                  retire_o           = 1'b1;
                  next_state_o       = ST_IF;
               end
               OP_CALL, OP_RET: next_state_o = ST_MEM;
               OP_HLT: begin
                  retire_o     = 1'b1;
                  next_state_o = ST_HALT;
               end
               default: begin
                  next_state_o  = ST_HALT;
                  set_illegal_o = 1'b1;
               end
            endcase
         end

         ST_EX: begin
            case (op_i)
               OP_ALU, OP_ADDI: begin
                  strobes_o.alu_src_imm = (op_i == OP_ADDI);
                  strobes_o.flags_write = 1'b1;
                  next_state_o          = ST_WB;
               end
               OP_LW, OP_SW: begin
                  strobes_o.alu_src_imm = 1'b1;
                  next_state_o          = ST_MEM;
               end
               default: begin
                  next_state_o  = ST_HALT;
                  set_illegal_o = 1'b1;
               end
            endcase
         end

         ST_MEM: begin
            case (op_i)
               OP_LW, OP_SW, OP_CALL, OP_RET: begin
                  // Request and write enable stay up through every stalled cycle
                  strobes_o.mem_req      = 1'b1;
                  strobes_o.mem_addr_sel = 1'b1;
                  strobes_o.mem_we       = (op_i == OP_SW) || (op_i == OP_CALL);
                  if (mem_ready_i) begin
                     if (op_i == OP_LW) begin
                        next_state_o = ST_WB;
                     end else begin
                        strobes_o.sp_dec   = (op_i == OP_CALL);
                        strobes_o.sp_inc   = (op_i == OP_RET);
                        strobes_o.pc_write = (op_i == OP_CALL) || (op_i == OP_RET);
                        retire_o           = 1'b1;
                        next_state_o       = ST_IF;
                     end
                  end
               end
               default: begin
                  next_state_o  = ST_HALT;
                  set_illegal_o = 1'b1;
               end
            endcase
         end

         ST_WB: begin
            strobes_o.reg_write = 1'b1;
            strobes_o.wb_sel    = (op_i == OP_LW);
            retire_o            = 1'b1;
            next_state_o        = ST_IF;
         end

         ST_HALT: next_state_o = ST_HALT;

         default: begin
            next_state_o  = ST_HALT;
            set_illegal_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multi-cycle IF/ID/EX/MEM/WB sequencer with halt and retire counter
module main_control_fsm
   import cpu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [5:0]           op,
   main_control_fsm_if.master   mem_bus,
   output logic [2:0]           state,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 alu_src_imm,
   output logic                 flags_write,
   output logic                 reg_write,
   output logic                 wb_sel,
   output logic                 sp_inc,
   output logic                 sp_dec,
   output logic                 halted,
   output logic                 illegal,
   output logic                 instr_retired,
   output logic [CNT_W-1:0]     instr_count
);

   logic [2:0]       state_q, state_d;
   logic             halted_q, halted_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] count_q, count_d;

   ctrl_strobes_t    dec_strobes;
   ctrl_strobes_t    strobes;
   logic [2:0]       dec_next;
   logic             dec_retire;
   logic             dec_set_illegal;

   ctrl_decode u_decode (
      .state_i       (state_q),
      .op_i          (op),
      .mem_ready_i   (mem_bus.mem_ready),
      .strobes_o     (dec_strobes),
      .next_state_o  (dec_next),
      .retire_o      (dec_retire),
      .set_illegal_o (dec_set_illegal)
   );

   always_comb begin
      state_d   = dec_next;
      halted_d  = halted_q | (dec_next == ST_HALT);
      illegal_d = illegal_q | dec_set_illegal;
      count_d   = count_q + CNT_W'(dec_retire);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IF;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
         count_q   <= count_d;
      end
   end

   // Strobes are silenced while reset is held so an abandoned instruction leaves no side effects
   assign strobes = rst_n ? dec_strobes : '0;

   assign mem_bus.mem_req      = strobes.mem_req;
   assign mem_bus.mem_we       = strobes.mem_we;
   assign mem_bus.mem_addr_sel = strobes.mem_addr_sel;
   assign ir_write             = strobes.ir_write;
   assign pc_write             = strobes.pc_write;
   assign alu_src_imm          = strobes.alu_src_imm;
   assign flags_write          = strobes.flags_write;
   assign reg_write            = strobes.reg_write;
   assign wb_sel               = strobes.wb_sel;
   assign sp_inc               = strobes.sp_inc;
   assign sp_dec               = strobes.sp_dec;
   assign instr_retired        = rst_n & dec_retire;

   assign state       = state_q;
   assign halted      = halted_q;
   assign illegal     = illegal_q;
   assign instr_count = count_q;

endmodule
